// File: rtl/branch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : branch_sequencer
// Description : Multi-cycle PC / branch controller. Owns the program counter
//               and the Z/N/C/V flag register, sequences FETCH -> EXEC against
//               instruction memory and redirects the PC on taken jumps.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_sequencer #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  input  logic            dec_jump,
  input  logic            dec_halt,
  input  logic [3:0]      jump_cond,
  input  logic [PC_W-1:0] jump_target,
  input  logic            stall,
  input  logic            alu_flags_we,
  input  logic            alu_z,
  input  logic            alu_n,
  input  logic            alu_c,
  input  logic            alu_v,
  output logic [PC_W-1:0] pc,
  output logic            fetch_req,
  output logic            exec_en,
  output logic            jump_taken,
  output logic [3:0]      flags_q,
  output logic            halted
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [PC_W-1:0] pc_nxt;
  logic            jump_nxt;
  logic            latch_en;
  logic            cond_true;

  // Instruction fields captured at the end of FETCH
  logic            lat_jump;
  logic            lat_halt;
  logic [3:0]      lat_cond;
  logic [PC_W-1:0] lat_target;

  // Flag aliases for readability of the condition table
  logic fz, fn, fc, fv;
  assign {fz, fn, fc, fv} = flags_q;

  // Condition evaluation on the registered flags; unused codes never take
  always_comb begin
    cond_true = 1'b0;
    case (lat_cond)
      4'b0000: cond_true = 1'b1;
      4'b0001: cond_true = fz;
      4'b0010: cond_true = ~fz;
      4'b0011: cond_true = ~fz & ~fn;
      4'b0100: cond_true = fn;
      4'b0101: cond_true = ~fn;
      4'b0110: cond_true = fz | fn;
      4'b0111: cond_true = fc;
      4'b1000: cond_true = fv;
      default: cond_true = 1'b0;
    endcase
  end

  // Next-state, next-PC and strobe decode
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    jump_nxt  = 1'b0;
    latch_en  = 1'b0;
    fetch_req = 1'b0;
    exec_en   = 1'b0;
    halted    = 1'b0;
    case (state)
      IDLE: state_nxt = FETCH;
      FETCH: begin
        fetch_req = 1'b1;
        if (instr_valid && !stall) begin
          latch_en  = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (!stall) begin
          exec_en   = 1'b1;
          state_nxt = FETCH;
          if (lat_halt) begin
            state_nxt = HALT;
          end else if (lat_jump && cond_true) begin
            pc_nxt   = lat_target;
            jump_nxt = 1'b1;
          end else begin
            pc_nxt = pc + PC_W'(1);
          end
        end
      end
      HALT: halted = 1'b1;
      default: state_nxt = IDLE;
    endcase
  end

  // Sequencer state, PC, jump pulse and latched instruction fields
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      jump_taken <= 1'b0;
      lat_jump   <= 1'b0;
      lat_halt   <= 1'b0;
      lat_cond   <= 4'd0;
      lat_target <= '0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      jump_taken <= jump_nxt;
      if (latch_en) begin
        lat_jump   <= dec_jump;
        lat_halt   <= dec_halt;
        lat_cond   <= jump_cond;
        lat_target <= jump_target;
      end
    end
  end

  // Flag register: written in any state, independent of stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 4'd0;
    end else if (alu_flags_we) begin
      flags_q <= {alu_z, alu_n, alu_c, alu_v};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_sequencer
// Description : Self-checking bench for branch_sequencer: directed sequences,
//               a condition-code vector table and randomized instructions
//               checked against an instruction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       instr_valid = 1'b0;
  logic       dec_jump = 1'b0;
  logic       dec_halt = 1'b0;
  logic [3:0] jump_cond = 4'd0;
  logic [7:0] jump_target = 8'd0;
  logic       stall = 1'b0;
  logic       alu_flags_we = 1'b0;
  logic       alu_z = 1'b0, alu_n = 1'b0, alu_c = 1'b0, alu_v = 1'b0;
  logic [7:0] pc;
  logic       fetch_req, exec_en, jump_taken, halted;
  logic [3:0] flags_q;

  branch_sequencer #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid),
    .dec_jump(dec_jump), .dec_halt(dec_halt), .jump_cond(jump_cond),
    .jump_target(jump_target), .stall(stall), .alu_flags_we(alu_flags_we),
    .alu_z(alu_z), .alu_n(alu_n), .alu_c(alu_c), .alu_v(alu_v),
    .pc(pc), .fetch_req(fetch_req), .exec_en(exec_en),
    .jump_taken(jump_taken), .flags_q(flags_q), .halted(halted)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         n_instr = 0;
  int         n_exec = 0;
  bit         rand_flags = 1'b0;
  logic [7:0] mpc = 8'd0;
  logic [3:0] mflags = 4'd0;

  typedef struct {
    logic [3:0] cc;
    logic [3:0] fl;
    logic       exp;
  } vec_t;
  vec_t tbl[$];

  // Count execute strobes, sampled mid-cycle
  always @(negedge clk) if (exec_en === 1'b1) n_exec++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural condition table on flags {Z,N,C,V}
  function automatic bit cond_holds(input logic [3:0] code, input logic [3:0] f);
    bit z, n, c, v;
    {z, n, c, v} = f;
    case (code)
      4'd0: return 1'b1;
      4'd1: return z;
      4'd2: return !z;
      4'd3: return !z && !n;
      4'd4: return n;
      4'd5: return !n;
      4'd6: return z || n;
      4'd7: return c;
      4'd8: return v;
      default: return 1'b0;
    endcase
  endfunction

  task automatic rand_alu();
    if (rand_flags) begin
      alu_flags_we = 1'($urandom_range(0, 1));
      {alu_z, alu_n, alu_c, alu_v} = 4'($urandom);
    end else begin
      alu_flags_we = 1'b0;
    end
  endtask

  task automatic garbage();
    dec_jump    = 1'($urandom);
    dec_halt    = 1'($urandom);
    jump_cond   = 4'($urandom);
    jump_target = 8'($urandom);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) mflags = 4'd0;
    else if (alu_flags_we) mflags = {alu_z, alu_n, alu_c, alu_v};
    #1;
    check("flags_q", 32'(flags_q), 32'(mflags));
  endtask

  task automatic set_flags(input logic [3:0] f);
    instr_valid  = 1'b0;
    stall        = 1'b0;
    alu_flags_we = 1'b1;
    {alu_z, alu_n, alu_c, alu_v} = f;
    tick();
    alu_flags_we = 1'b0;
  endtask

  // One instruction from FETCH through EXEC, checked against the model
  task automatic do_instr(input bit j, input bit h, input logic [3:0] cc,
                          input logic [7:0] tgt, input int fw, input int es,
                          input bit we_ex, input logic [3:0] f_ex,
                          output logic obs_taken);
    bit taken;
    check("fetch_req", 32'(fetch_req), 1);
    check("fetch_pc", 32'(pc), 32'(mpc));
    for (int i = 0; i < fw; i++) begin
      instr_valid = 1'($urandom);
      stall = instr_valid ? 1'b1 : 1'($urandom);
      garbage();
      rand_alu();
      tick();
      check("fetch_hold", 32'({fetch_req, exec_en, jump_taken}), 32'b100);
      check("fetch_hold_pc", 32'(pc), 32'(mpc));
    end
    instr_valid = 1'b1;
    stall       = 1'b0;
    dec_jump    = j;
    dec_halt    = h;
    jump_cond   = cc;
    jump_target = tgt;
    rand_alu();
    tick();
    check("enter_exec", 32'({fetch_req, jump_taken, halted}), 0);
    check("enter_exec_pc", 32'(pc), 32'(mpc));
    for (int i = 0; i < es; i++) begin
      instr_valid = 1'($urandom);
      stall = 1'b1;
      garbage();
      rand_alu();
      #1;
      check("stall_exec_en", 32'(exec_en), 0);
      tick();
      check("stall_pc", 32'(pc), 32'(mpc));
      check("stall_no_fetch", 32'(fetch_req), 0);
    end
    stall = 1'b0;
    instr_valid = 1'($urandom);
    garbage();
    if (we_ex) begin
      alu_flags_we = 1'b1;
      {alu_z, alu_n, alu_c, alu_v} = f_ex;
    end else begin
      rand_alu();
    end
    #1;
    check("exec_en", 32'(exec_en), 1);
    taken = !h && j && cond_holds(cc, mflags);
    tick();
    n_instr++;
    if (!h) mpc = taken ? tgt : mpc + 8'd1;
    check("jump_taken", 32'(jump_taken), 32'(taken));
    check("exec_pc", 32'(pc), 32'(mpc));
    check("halted", 32'(halted), 32'(h));
    check("fetch_after", 32'(fetch_req), 32'(!h));
    obs_taken    = jump_taken;
    instr_valid  = 1'b0;
    stall        = 1'b0;
    alu_flags_we = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pc"}, 32'(pc), 0);
    check({tag, "_outs"}, 32'({fetch_req, exec_en, jump_taken, halted}), 0);
    check({tag, "_flags"}, 32'(flags_q), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic obs;
    int   ex0;

    // Condition vectors: {code, flags {Z,N,C,V}, expected taken}
    tbl.push_back('{4'd3, 4'b0000, 1'b1});
    tbl.push_back('{4'd3, 4'b0100, 1'b0});
    tbl.push_back('{4'd3, 4'b1000, 1'b0});
    tbl.push_back('{4'd3, 4'b1100, 1'b0});
    tbl.push_back('{4'd6, 4'b0000, 1'b0});
    tbl.push_back('{4'd6, 4'b0100, 1'b1});
    tbl.push_back('{4'd6, 4'b1000, 1'b1});
    tbl.push_back('{4'd6, 4'b1100, 1'b1});
    tbl.push_back('{4'd7, 4'b0010, 1'b1});
    tbl.push_back('{4'd7, 4'b1101, 1'b0});
    tbl.push_back('{4'd8, 4'b0001, 1'b1});
    tbl.push_back('{4'd8, 4'b1110, 1'b0});
    tbl.push_back('{4'd4, 4'b0100, 1'b1});
    tbl.push_back('{4'd5, 4'b0100, 1'b0});
    tbl.push_back('{4'd2, 4'b1000, 1'b0});
    for (int c = 9; c <= 15; c++) begin
      tbl.push_back('{4'(c), 4'b1111, 1'b0});
      tbl.push_back('{4'(c), 4'b0000, 1'b0});
    end

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    #1;
    check("idle_no_fetch", 32'(fetch_req), 0);
    tick();
    check("first_fetch", 32'(fetch_req), 1);

    // Straight-line code, 2-cycle instruction period
    for (int i = 0; i < 4; i++) do_instr(0, 0, 4'd0, 8'h00, 0, 0, 0, 4'd0, obs);
    check("seq_pc", 32'(pc), 4);
    check("seq_exec_count", n_exec, n_instr);

    // JEQ taken with Z=1, not taken with Z=0
    set_flags(4'b1000);
    do_instr(1, 0, 4'd1, 8'h40, 0, 0, 0, 4'd0, obs);
    check("jeq_taken", 32'(obs), 1);
    tick();
    check("jeq_pulse_one_cycle", 32'(jump_taken), 0);
    set_flags(4'b0000);
    do_instr(1, 0, 4'd1, 8'h70, 0, 0, 0, 4'd0, obs);
    check("jeq_not_taken", 32'(obs), 0);
    check("jeq_not_taken_pc", 32'(pc), 32'h41);

    // Same-cycle flag write: jump uses the old flags
    do_instr(1, 0, 4'd1, 8'h90, 0, 0, 1, 4'b1000, obs);
    check("hazard_old_flags", 32'(obs), 0);
    check("hazard_pc", 32'(pc), 32'h42);
    do_instr(1, 0, 4'd1, 8'h80, 0, 0, 0, 4'd0, obs);
    check("hazard_next_taken", 32'(obs), 1);
    check("hazard_next_pc", 32'(pc), 32'h80);

    // Condition table
    for (int i = 0; i < tbl.size(); i++) begin
      set_flags(tbl[i].fl);
      do_instr(1, 0, tbl[i].cc, 8'h10 + 8'(i), 0, 0, 0, 4'd0, obs);
      check($sformatf("table_%0d_code%0d", i, tbl[i].cc), 32'(obs), 32'(tbl[i].exp));
    end

    // PC wrap at 0xFF, with a 3-cycle EXEC stall
    do_instr(1, 0, 4'd0, 8'hFF, 0, 0, 0, 4'd0, obs);
    check("wrap_pre_pc", 32'(pc), 32'hFF);
    ex0 = n_exec;
    do_instr(0, 0, 4'd0, 8'h00, 1, 3, 0, 4'd0, obs);
    check("wrap_pc", 32'(pc), 0);
    check("stall_single_exec", n_exec - ex0, 1);

    // Randomized instruction stream
    rand_flags = 1'b1;
    for (int i = 0; i < 200; i++) begin
      do_instr(1'($urandom), 1'b0, 4'($urandom), 8'($urandom),
               int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
               1'b0, 4'd0, obs);
    end
    rand_flags = 1'b0;
    check("rand_exec_count", n_exec, n_instr);

    // HALT at pc=5
    do_instr(1, 0, 4'd0, 8'h05, 0, 0, 0, 4'd0, obs);
    do_instr(0, 1, 4'd0, 8'h00, 0, 1, 0, 4'd0, obs);
    rand_flags = 1'b1;
    for (int i = 0; i < 10; i++) begin
      instr_valid = 1'($urandom);
      stall = 1'($urandom);
      garbage();
      rand_alu();
      tick();
      check("halt_state", 32'({halted, fetch_req, exec_en, jump_taken}), 32'b1000);
      check("halt_pc", 32'(pc), 5);
    end
    rand_flags = 1'b0;
    alu_flags_we = 1'b0;
    instr_valid = 1'b0;
    check("halt_exec_count", n_exec, n_instr);

    // Asynchronous reset out of HALT
    rst_n = 1'b0;
    mpc = 8'd0;
    mflags = 4'd0;
    #1;
    check_reset_outputs("halt_reset");
    tick();
    rst_n = 1'b1;
    tick();
    do_instr(0, 0, 4'd0, 8'h00, 0, 0, 0, 4'd0, obs);

    // Asynchronous reset in the middle of EXEC of a taken jump
    instr_valid = 1'b1;
    dec_jump = 1'b1;
    dec_halt = 1'b0;
    jump_cond = 4'd0;
    jump_target = 8'h33;
    tick();
    instr_valid = 1'b0;
    #1;
    check("midexec_exec_en", 32'(exec_en), 1);
    #1;
    rst_n = 1'b0;
    mpc = 8'd0;
    mflags = 4'd0;
    #1;
    check_reset_outputs("midexec_reset");
    tick();
    check("midexec_no_pulse", 32'(jump_taken), 0);
    check("midexec_pc_held", 32'(pc), 0);
    rst_n = 1'b1;
    #1;
    check("post_reset_idle", 32'(fetch_req), 0);
    tick();
    do_instr(0, 0, 4'd0, 8'h00, 0, 0, 0, 4'd0, obs);
    check("post_reset_pc", 32'(pc), 1);
    check("final_exec_count", n_exec, n_instr);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
